// File: rtl/sale_pkg.sv
// Shared types and constants for the ticket payment path.
// Holds the FSM state encoding, coin values, datapath widths and fare arithmetic helpers.
package sale_pkg;

  localparam int unsigned PRICE_W     = 4;
  localparam int unsigned TOTAL_W     = 6;
  localparam int unsigned MONEY_W     = 7;
  localparam int unsigned MAX_TICKETS = 3;
  localparam int unsigned TICKET_W    = $clog2(MAX_TICKETS + 1);

  localparam int unsigned COIN1  = 1;
  localparam int unsigned COIN5  = 5;
  localparam int unsigned COIN10 = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_PAY    = 3'd2,
    ST_DONE   = 3'd3,
    ST_REFUND = 3'd4
  } state_e;

  // A request for zero tickets is sold as a single ticket.
  function automatic logic [TICKET_W-1:0] norm_tickets(input logic [TICKET_W-1:0] n);
    return (n == '0) ? TICKET_W'(1) : n;
  endfunction

  function automatic logic [TOTAL_W-1:0] calc_total(input logic [PRICE_W-1:0]  fare,
                                                    input logic [TICKET_W-1:0] tickets);
    return TOTAL_W'(fare) * TOTAL_W'(tickets);
  endfunction

endpackage

// File: rtl/coin_accum.sv
// Per-cycle coin summation feeding a saturating paid-amount register.
// paid_next exposes this cycle's running total so the FSM can decide without a cycle of lag.
module coin_accum
  import sale_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               coin_1_i,
  input  logic               coin_5_i,
  input  logic               coin_10_i,
  output logic [MONEY_W-1:0] paid_o,
  output logic [MONEY_W-1:0] paid_next_o,
  output logic               coin_seen_o
);

  logic [MONEY_W-1:0] paid_q;
  logic [MONEY_W-1:0] coin_sum;
  logic [MONEY_W:0]   sum_raw;

  always_comb begin
    coin_sum = '0;
    if (coin_1_i)  coin_sum = coin_sum + MONEY_W'(COIN1);
    if (coin_5_i)  coin_sum = coin_sum + MONEY_W'(COIN5);
    if (coin_10_i) coin_sum = coin_sum + MONEY_W'(COIN10);
    sum_raw = {1'b0, paid_q} + {1'b0, coin_sum};
    paid_next_o = paid_q;
    if (en_i) paid_next_o = sum_raw[MONEY_W] ? '1 : sum_raw[MONEY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) paid_q <= '0;
    else              paid_q <= paid_next_o;
  end

  assign paid_o      = paid_q;
  assign coin_seen_o = coin_1_i | coin_5_i | coin_10_i;

endmodule

// File: rtl/ticket_pay_ctrl.sv
// Payment FSM: waits for the fare from the price RAM, collects coins, then
// dispenses with change or refunds on cancel/timeout.
module ticket_pay_ctrl
  import sale_pkg::*;
#(
  parameter int unsigned PRICE_LAT   = 2,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                select_done,
  input  logic [PRICE_W-1:0]  price,
  input  logic [TICKET_W-1:0] ticket_num,
  input  logic                coin_1,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                cancel,
  output logic [TOTAL_W-1:0]  total,
  output logic [MONEY_W-1:0]  paid,
  output logic [MONEY_W-1:0]  change,
  output logic                dispense,
  output logic                refund,
  output logic                err,
  output logic                busy,
  output logic [2:0]          state
);

  localparam int unsigned LAT_W = $clog2(PRICE_LAT) + 1;
  localparam int unsigned TMO_W = 28;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PRICE_LAT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e              state_q;
  logic [LAT_W-1:0]    lat_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [TICKET_W-1:0] tickets_q;
  logic [TOTAL_W-1:0]  total_q;
  logic [MONEY_W-1:0]  change_q;
  logic                dispense_q, refund_q, err_q;

  logic [MONEY_W-1:0]  paid_next;
  logic                coin_seen;
  logic                accum_clr;

  // A new transaction clears the coin count whenever LATCH is (re)entered.
  assign accum_clr = select_done && (state_q == ST_IDLE || state_q == ST_LATCH);

  coin_accum u_accum (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (accum_clr),
    .en_i        (state_q == ST_PAY),
    .coin_1_i    (coin_1),
    .coin_5_i    (coin_5),
    .coin_10_i   (coin_10),
    .paid_o      (paid),
    .paid_next_o (paid_next),
    .coin_seen_o (coin_seen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      tmo_q      <= '0;
      tickets_q  <= '0;
      total_q    <= '0;
      change_q   <= '0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (select_done) begin
            state_q   <= ST_LATCH;
            lat_q     <= '0;
            tickets_q <= norm_tickets(ticket_num);
            total_q   <= '0;
            change_q  <= '0;
          end
        end
        ST_LATCH: begin
          if (select_done) begin
            lat_q     <= '0;
            tickets_q <= norm_tickets(ticket_num);
          end else if (lat_q == LAT_LAST) begin
            if (price == '0) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              total_q <= calc_total(price, tickets_q);
              tmo_q   <= '0;
              state_q <= ST_PAY;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_PAY: begin
          tmo_q <= coin_seen ? '0 : tmo_q + 1'b1;
          // Cancel/timeout win over completion; both use the paid value including this cycle's coins.
          if (cancel || tmo_q == TMO_LAST) begin
            refund_q <= 1'b1;
            change_q <= paid_next;
            state_q  <= ST_REFUND;
          end else if (paid_next >= MONEY_W'(total_q)) begin
            dispense_q <= 1'b1;
            change_q   <= paid_next - MONEY_W'(total_q);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE:   state_q <= ST_IDLE;
        ST_REFUND: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign total    = total_q;
  assign change   = change_q;
  assign dispense = dispense_q;
  assign refund   = refund_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_ticket_pay_ctrl.sv
// Scoreboard bench for ticket_pay_ctrl: expected results are queued as stimulus
// is driven and checked when dispense/refund/err appears.
module tb_ticket_pay_ctrl;
  import sale_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       select_done = 1'b0;
  logic [3:0] price = '0;
  logic [1:0] ticket_num = '0;
  logic       coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0, cancel = 1'b0;
  logic [5:0] total;
  logic [6:0] paid, change;
  logic       dispense, refund, err, busy;
  logic [2:0] state;

  always #5 clk = ~clk;

  ticket_pay_ctrl #(.PRICE_LAT(2), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .select_done(select_done), .price(price), .ticket_num(ticket_num),
    .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10), .cancel(cancel),
    .total(total), .paid(paid), .change(change), .dispense(dispense), .refund(refund),
    .err(err), .busy(busy), .state(state)
  );

  typedef struct packed {
    logic [2:0] pulses;   // {err, refund, dispense}
    logic [6:0] change;
    logic [6:0] paid;
  } res_t;

  res_t exp_q[$];
  res_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int max_cyc, output bit found);
    found = dispense | refund | err;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick();
      found = dispense | refund | err;
    end
  endtask

  // Fare is valid only in the cycle the block must sample it; 4'hF elsewhere.
  task automatic start_txn(input logic [3:0] p, input logic [1:0] n);
    select_done = 1'b1; ticket_num = n; price = 4'hF;
    tick();
    select_done = 1'b0; ticket_num = 2'd3;
    tick();
    price = p;
    tick();
    price = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({total, paid, change, dispense, refund, err, busy, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got total=%0d paid=%0d change=%0d disp=%b ref=%b err=%b busy=%b state=%0d, expected all 0",
               total, paid, change, dispense, refund, err, busy, state);
    end
  endtask

  task automatic test_basic();
    select_done = 1'b1; ticket_num = 2'd2; price = 4'hF;
    tick();
    select_done = 1'b0; ticket_num = 2'd0;
    n_tests++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_latch1: got state=%0d busy=%b, expected state=1 busy=1", state, busy);
    end
    tick();
    n_tests++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL basic_latch2: got state=%0d, expected 1", state);
    end
    price = 4'd4;
    tick();
    price = 4'hF;
    n_tests++;
    if (state !== 3'd2 || total !== 6'd8 || paid !== 7'd0) begin
      n_fail++; $display("FAIL basic_pay_entry: got state=%0d total=%0d paid=%0d, expected 2/8/0", state, total, paid);
    end
    exp_q.push_back('{3'b001, 7'd2, 7'd10});
    coin_10 = 1'b1;
    tick();
    coin_10 = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL basic_result: no result pulse, expected dispense");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e || state !== 3'd3) begin
        n_fail++;
        $display("FAIL basic_result: got pulses=%b change=%0d paid=%0d state=%0d, expected pulses=%b change=%0d paid=%0d state=3",
                 {err, refund, dispense}, change, paid, state, e.pulses, e.change, e.paid);
      end
    end
    tick();
    n_tests++;
    if (state !== 3'd0 || dispense !== 1'b0 || busy !== 1'b0 || total !== 6'd8 || paid !== 7'd10 || change !== 7'd2) begin
      n_fail++;
      $display("FAIL basic_idle_hold: got state=%0d disp=%b busy=%b total=%0d paid=%0d change=%0d, expected 0/0/0/8/10/2",
               state, dispense, busy, total, paid, change);
    end
  endtask

  task automatic test_multi_coin();
    start_txn(4'd7, 2'd3);
    n_tests++;
    if (state !== 3'd2 || total !== 6'd21 || paid !== 7'd0 || change !== 7'd0) begin
      n_fail++; $display("FAIL multi_entry: got state=%0d total=%0d paid=%0d change=%0d, expected 2/21/0/0", state, total, paid, change);
    end
    for (int k = 1; k <= 4; k++) begin
      coin_5 = 1'b1;
      tick();
      coin_5 = 1'b0;
      n_tests++;
      if (paid !== 7'(5 * k) || dispense !== 1'b0 || state !== 3'd2) begin
        n_fail++; $display("FAIL multi_paid%0d: got paid=%0d disp=%b state=%0d, expected %0d/0/2", k, paid, dispense, state, 5 * k);
      end
      tick();
    end
    exp_q.push_back('{3'b001, 7'd0, 7'd21});
    coin_1 = 1'b1;
    tick();
    coin_1 = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL multi_result: no result pulse, expected dispense");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL multi_result: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
  endtask

  task automatic test_simultaneous_coins();
    start_txn(4'd3, 2'd0);
    n_tests++;
    if (total !== 6'd3) begin
      n_fail++; $display("FAIL simul_total: got %0d, expected 3", total);
    end
    exp_q.push_back('{3'b001, 7'd3, 7'd6});
    coin_1 = 1'b1; coin_5 = 1'b1;
    tick();
    coin_1 = 1'b0; coin_5 = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL simul_result: no result pulse, expected dispense");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL simul_result: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
  endtask

  task automatic test_cancel();
    start_txn(4'd9, 2'd1);
    coin_5 = 1'b1;
    tick();
    coin_5 = 1'b0;
    exp_q.push_back('{3'b010, 7'd6, 7'd6});
    coin_1 = 1'b1; cancel = 1'b1;
    tick();
    coin_1 = 1'b0; cancel = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL cancel_result: no result pulse, expected refund");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e || state !== 3'd4) begin
        n_fail++; $display("FAIL cancel_result: got pulses=%b change=%0d paid=%0d state=%0d, expected pulses=%b change=%0d paid=%0d state=4",
                           {err, refund, dispense}, change, paid, state, e.pulses, e.change, e.paid);
      end
    end
    tick();
    n_tests++;
    if (dispense !== 1'b0 || refund !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL cancel_after: got disp=%b ref=%b state=%0d, expected 0/0/0", dispense, refund, state);
    end
    // Enough coin to complete, but cancel in the same cycle must still refund.
    start_txn(4'd1, 2'd1);
    exp_q.push_back('{3'b010, 7'd10, 7'd10});
    coin_10 = 1'b1; cancel = 1'b1;
    tick();
    coin_10 = 1'b0; cancel = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL cancel_priority: no result pulse, expected refund");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL cancel_priority: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
  endtask

  task automatic test_zero_fare();
    exp_q.push_back('{3'b100, 7'd0, 7'd0});
    start_txn(4'd0, 2'd2);
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL zero_fare_result: no result pulse, expected err");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e || busy !== 1'b0 || state !== 3'd0 || total !== 6'd0) begin
        n_fail++; $display("FAIL zero_fare_result: got pulses=%b change=%0d paid=%0d busy=%b state=%0d total=%0d, expected pulses=%b 0/0/0/0/0",
                           {err, refund, dispense}, change, paid, busy, state, total, e.pulses);
      end
    end
    tick();
    n_tests++;
    if (err !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL zero_fare_once: got err=%b state=%0d, expected 0/0", err, state);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_txn(4'd5, 2'd1);
    exp_q.push_back('{3'b010, 7'd0, 7'd0});
    n = 0;
    while (n < 40 && !refund) begin
      tick();
      n++;
    end
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0 || n != 20) begin
      n_fail++; $display("FAIL timeout_plain: got refund after %0d cycles (seen=%b), expected 20", n, seen);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL timeout_plain: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
    // A coin on the 10th PAY edge restarts the idle count: refund lands 20 cycles later.
    start_txn(4'd5, 2'd1);
    exp_q.push_back('{3'b010, 7'd1, 7'd1});
    n = 0;
    while (n < 60 && !refund) begin
      coin_1 = (n == 9);
      tick();
      coin_1 = 1'b0;
      n++;
    end
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0 || n != 30) begin
      n_fail++; $display("FAIL timeout_reload: got refund after %0d cycles (seen=%b), expected 30", n, seen);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL timeout_reload: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_pay();
    start_txn(4'd9, 2'd1);
    coin_5 = 1'b1;
    tick();
    coin_5 = 1'b0;
    n_tests++;
    if (paid !== 7'd5) begin
      n_fail++; $display("FAIL rst_pre_paid: got %0d, expected 5", paid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({total, paid, change, dispense, refund, err, busy, state} !== '0) begin
      n_fail++; $display("FAIL rst_mid_pay: got total=%0d paid=%0d change=%0d disp=%b ref=%b err=%b busy=%b state=%0d, expected all 0",
                         total, paid, change, dispense, refund, err, busy, state);
    end
    for (int i = 0; i < 3; i++) begin
      coin_10 = (i == 0);
      tick();
      coin_10 = 1'b0;
      n_tests++;
      if (paid !== 7'd0 || dispense !== 1'b0 || refund !== 1'b0 || state !== 3'd0) begin
        n_fail++; $display("FAIL idle_coin%0d: got paid=%0d disp=%b ref=%b state=%0d, expected 0/0/0/0", i, paid, dispense, refund, state);
      end
    end
  endtask

  task automatic test_back_to_back();
    select_done = 1'b1; ticket_num = 2'd1; price = 4'hF;
    tick();
    select_done = 1'b1; ticket_num = 2'd2;
    tick();
    select_done = 1'b0; ticket_num = 2'd3;
    tick();
    price = 4'd6;
    tick();
    price = 4'hF;
    n_tests++;
    if (state !== 3'd2 || total !== 6'd12) begin
      n_fail++; $display("FAIL restart_total: got state=%0d total=%0d, expected 2/12", state, total);
    end
    select_done = 1'b1; ticket_num = 2'd1;
    tick();
    select_done = 1'b0;
    n_tests++;
    if (state !== 3'd2 || total !== 6'd12 || paid !== 7'd0) begin
      n_fail++; $display("FAIL select_in_pay: got state=%0d total=%0d paid=%0d, expected 2/12/0", state, total, paid);
    end
    exp_q.push_back('{3'b001, 7'd3, 7'd15});
    coin_10 = 1'b1; coin_5 = 1'b1;
    tick();
    coin_10 = 1'b0; coin_5 = 1'b0;
    wait_pulse(0, seen);
    n_tests++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL b2b_result: no result pulse, expected dispense");
    end else begin
      e = exp_q.pop_front();
      if ({err, refund, dispense, change, paid} !== e) begin
        n_fail++; $display("FAIL b2b_result: got pulses=%b change=%0d paid=%0d, expected pulses=%b change=%0d paid=%0d",
                           {err, refund, dispense}, change, paid, e.pulses, e.change, e.paid);
      end
    end
    tick();
    start_txn(4'd2, 2'd2);
    n_tests++;
    if (state !== 3'd2 || total !== 6'd4 || paid !== 7'd0 || change !== 7'd0) begin
      n_fail++; $display("FAIL b2b_second: got state=%0d total=%0d paid=%0d change=%0d, expected 2/4/0/0", state, total, paid, change);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_coin();
    test_simultaneous_coins();
    test_cancel();
    test_zero_fare();
    test_timeout();
    test_reset_mid_pay();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ticket_pay_ctrl.md
Name: ticket_pay_ctrl

Overview:
- Payment stage directly downstream of the fare-lookup RAM stage.
- After the passenger confirms a route, it waits for the 4-bit fare read from the price RAM, then latches it and multiplies it by the ticket count.
- It accumulates coin pulses and issues dispense/change or refund results to the display and actuator logic.
- Runs on the display clock domain (clk_disp) used by the fare lookup.

Parameters:
- PRICE_LAT, 2, cycles from select_done until the price input is valid (RAM address register plus read latency).
- TIMEOUT_CYC, 250000000, idle cycles allowed in PAY before automatic refund (10 s at 25 MHz); the counter is 28 bits.

Ports:
- clk  in  1  clock (clk_disp from the clock wizard)
- rst  in  1  reset; synchronous, active-high
- select_done  in  1  one-cycle pulse: route and count are final, and the upstream address is now stable
- price  in  4  fare per ticket, taken from the price RAM douta[3:0]
- ticket_num  in  2  tickets requested, 1..3; 0 is treated as 1
- coin_1  in  1  one-cycle pulse: 1-yuan coin inserted
- coin_5  in  1  one-cycle pulse: 5-yuan coin inserted
- coin_10  in  1  one-cycle pulse: 10-yuan coin inserted
- cancel  in  1  one-cycle pulse: passenger aborts
- total  out  6  fare x tickets; maximum 45
- paid  out  7  coins accumulated this transaction
- change  out  7  change or refund amount
- dispense  out  1  one-cycle pulse: issue tickets
- refund  out  1  one-cycle pulse: return change (refund) coins
- err  out  1  one-cycle pulse: fare of zero (invalid route)
- busy  out  1  high in every state except IDLE
- state  out  3  current state encoding, for the VGA/segment display

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, and all counters are 0. rst asserted mid-transaction discards paid coins with no refund pulse; the accumulated-coin count is lost.
- IDLE:
  - select_done starts a LATCH state with lat_cnt=0 and captures ticket_num (0 becomes 1).
  - Outputs total, paid and change hold their last values until select_done, then clear to 0 on entry to LATCH.
  - Coins and cancel are ignored.
- LATCH:
  - lat_cnt increments each cycle.
  - When lat_cnt==PRICE_LAT-1, the block samples price on that cycle.
  - If price==0: pulse err and go to IDLE.
  - Otherwise: total=price*tickets (6-bit, no overflow possible) and go to PAY.
  - The latency from select_done to PAY is PRICE_LAT+1 cycles.
  - A select_done received during LATCH restarts LATCH (lat_cnt=0, ticket_num recaptured).
- PAY:
  - Each cycle, paid += 1*coin_1 + 5*coin_5 + 10*coin_10. Simultaneous pulses all count. paid saturates at 127, which cannot be reached in practice because the maximum is 44+16=60.
  - Any coin pulse reloads the timeout counter to 0; otherwise it increments.
  - If cancel is asserted, or the timeout counter reaches TIMEOUT_CYC-1, go to REFUND. Coins arriving in that same cycle are included in paid.
  - Cancel has priority over completion.
  - If there is no cancel or timeout and (paid + this cycle's coins) >= total, go to DONE.
  - select_done is ignored in PAY.
- DONE (1 cycle): pulse dispense, set change = paid - total, go to IDLE.
- REFUND (1 cycle): pulse refund, set change = paid, go to IDLE. If paid==0, still pulse refund with change=0.
- Coins arriving in any state other than PAY are ignored and not counted; the mechanical coin return handles them.
- State encoding: IDLE=0, LATCH=1, PAY=2, DONE=3, REFUND=4. Unused encodings go to IDLE on the next cycle.

Decomposition:
- Shared package sale_pkg holds:
  - the state enum and encodings;
  - coin value constants (COIN1=1, COIN5=5, COIN10=10);
  - width constants (PRICE_W=4, TOTAL_W=6, MONEY_W=7);
  - MAX_TICKETS=3.
- One natural sub-module, coin_accum: a per-cycle coin sum plus saturating accumulator, with clear and enable inputs. The FSM stays in the top module.

Test Plan:
- select_done with price=4, ticket_num=2, then coin_10 -> PAY is reached PRICE_LAT+1 cycles after select_done; total=8; next cycle DONE with dispense=1, change=2; then IDLE.
- price=7, ticket_num=3, then coin_5 x4 on separate cycles -> paid reads 5, 10, 15, 20; dispense fires after the 5th... correction: coins 5, 10, 15 leave paid below 21, and the 4th coin makes paid=20 <21, so no dispense; a further coin_1 -> dispense=1 with change=0.
- price=3, ticket_num=1; coin_1 and coin_5 in the same cycle -> paid=6, dispense=1, change=3.
- price=9, ticket_num=1; coin_5 then cancel in the same cycle as coin_1 -> refund=1, change=6, dispense never asserted.
- price=0 -> err pulses once, busy drops, no PAY entry. Separately: price=5 with no coins and TIMEOUT_CYC=20 -> refund pulses with change=0 exactly 20 cycles after entering PAY.
- rst asserted during PAY with paid=5 -> next cycle all outputs are 0, state=IDLE, and no refund or dispense pulse. A coin_10 pulse in IDLE -> paid stays 0.
